alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Pipeline stage directly upstream of the ALU. It accepts a raw RV32I instruction plus register-file operands over a valid/ready handshake and decodes OP, OP-IMM and LUI into the ALU's 4-bit operation code and two 32-bit operands. It registers the result with a 2-entry skid buffer so that backpressure from the execute stage never creates a combinational ready path. Outputs drive the ALU's in_1/in_2/operation inputs directly, plus writeback metadata.

Parameters:
- XLEN, 32, operand/data width (only 32 is supported)
- OP_W, 4, ALU operation code width

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- flush  input  1  synchronous; drops all buffered entries
- in_valid  input  1  upstream has an instruction
- in_ready  output  1  stage can accept this cycle
- instr  input  32  instruction word
- rs1_data  input  32  register-file read of instr[19:15]
- rs2_data  input  32  register-file read of instr[24:20]
- out_valid  output  1  ALU operands valid
- out_ready  input  1  downstream consumes this cycle
- alu_in_1  output  32  ALU first operand
- alu_in_2  output  32  ALU second operand
- alu_op  output  4  ADD=0 SUB=1 XOR=2 OR=3 AND=4 SLL=5 SRL=6 SRA=7 SLT=8 SLTU=9
- rd  output  5  destination register
- rd_we  output  1  write-back enable
- illegal  output  1  instruction is not OP/OP-IMM/LUI

Behaviour:
- Reset (rst_n low, asynchronous): state EMPTY; out_valid=0, alu_in_1=0, alu_in_2=0, alu_op=0, rd=0, rd_we=0, illegal=0, and skid entry cleared. in_ready=1 once state is EMPTY. Inputs are ignored while rst_n is low.
- Handshake: transfer on in_valid&in_ready (accept) or out_valid&out_ready (pop). in_valid must not depend on in_ready. in_ready is a function of state only (no combinational path from out_ready).
- States:
  - EMPTY (out_valid=0, in_ready=1): accept -> FULL.
  - FULL (out_valid=1, in_ready=1): accept&pop -> FULL with the new entry. Accept without pop -> SKID, with the new entry in the skid slot. Pop without accept -> EMPTY.
  - SKID (out_valid=1, in_ready=0): pop -> FULL, with the skid entry moved to the output.
- Latency: an entry accepted at edge N is visible at the outputs after edge N. Throughput is 1 per cycle when out_ready stays high.
- Outputs hold stable while out_valid=1 and out_ready=0.
- flush: the next state is EMPTY regardless of other inputs. A simultaneous accept is discarded. Output registers may retain stale data but out_valid=0.
- Decode (opcode instr[6:0], funct3 instr[14:12], funct7 instr[31:25]):
  - OP (0110011): in_1=rs1_data, in_2=rs2_data.
    - funct3 000 -> SUB if funct7=0100000, else ADD.
    - 001 SLL, 010 SLT, 011 SLTU, 100 XOR.
    - 101 -> SRA if funct7[5], else SRL.
    - 110 OR, 111 AND.
  - OP-IMM (0010011): in_1=rs1_data, in_2=sign-extended instr[31:20]. Same funct3 map, except:
    - 000 is always ADD.
    - Shifts use in_2={27'b0,instr[24:20]}; SRAI is selected by instr[30].
  - LUI (0110111): in_1=0, in_2={instr[31:12],12'b0}, op ADD.
  - Any other opcode: illegal=1, rd_we=0, op ADD, in_1=in_2=0. It still occupies a slot and flows downstream.
- rd=instr[11:7]. rd_we=1 only for legal instructions with rd!=0.
- funct7 bits other than bit 5 are not checked (no illegal flag for them).

Decomposition:
- Shared package alu_pkg: ALU op code constants (ADD..SLTU, 4-bit), opcode constants OPC_OP/OPC_OP_IMM/OPC_LUI, and the state encoding.
- One combinational sub-module, alu_op_decode: instr, rs1_data, rs2_data in; alu_in_1, alu_in_2, alu_op, rd, rd_we, illegal out.
- The top level instantiates alu_op_decode once and holds the state machine, the output register and the skid register.

Test Plan:
- Reset: rst_n low mid-stream with out_valid=1 -> out_valid=0 and in_ready=1 immediately (asynchronous); all outputs 0.
- Decode: SUB x3,x1,x2 (0x402081B3) with rs1=5, rs2=7 -> alu_op=1, alu_in_1=5, alu_in_2=7, rd=3, rd_we=1.
- Immediate: ADDI x1,x0,-1 (0xFFF00093) -> alu_in_2=0xFFFFFFFF, alu_op=0. SRAI x2,x2,4 (0x40415113) -> alu_op=7, alu_in_2=4. LUI x5,0x12345 (0x123452B7) -> alu_in_1=0, alu_in_2=0x12345000.
- Backpressure: stream A,B,C with out_ready=0 -> A accepted, B accepted into skid, then in_ready=0 and C stalls. Raise out_ready -> A,B,C emerge in order, none lost or duplicated.
- Flush: flush with the SKID state occupied and in_valid=1 -> next cycle out_valid=0, in_ready=1, and the incoming instruction does not appear.
- Illegal/x0: opcode 0000011 -> illegal=1, rd_we=0. ADD x0,x1,x2 -> rd_we=0, illegal=0.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared constants, state encoding and entry type for the ALU issue stage
// Contents:
//   ALU_XLEN / ALU_OP_W : data and operation-code widths
//   ALU_ADD..ALU_SLTU   : 4-bit ALU operation codes
//   OPC_*               : RV32I major opcodes handled by the stage
//   state_t             : skid-buffer occupancy state
//   entry_t             : one decoded instruction as held in the output/skid registers
//   funct3_op()         : funct3/funct7 to ALU operation mapping shared by OP and OP-IMM
package alu_pkg;

    localparam int ALU_XLEN = 32;
    localparam int ALU_OP_W = 4;

    localparam logic [ALU_OP_W-1:0] ALU_ADD  = 4'd0;
    localparam logic [ALU_OP_W-1:0] ALU_SUB  = 4'd1;
    localparam logic [ALU_OP_W-1:0] ALU_XOR  = 4'd2;
    localparam logic [ALU_OP_W-1:0] ALU_OR   = 4'd3;
    localparam logic [ALU_OP_W-1:0] ALU_AND  = 4'd4;
    localparam logic [ALU_OP_W-1:0] ALU_SLL  = 4'd5;
    localparam logic [ALU_OP_W-1:0] ALU_SRL  = 4'd6;
    localparam logic [ALU_OP_W-1:0] ALU_SRA  = 4'd7;
    localparam logic [ALU_OP_W-1:0] ALU_SLT  = 4'd8;
    localparam logic [ALU_OP_W-1:0] ALU_SLTU = 4'd9;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_FULL  = 2'd1,
        ST_SKID  = 2'd2
    } state_t;

    typedef struct packed {
        logic [ALU_XLEN-1:0] in_1;
        logic [ALU_XLEN-1:0] in_2;
        logic [ALU_OP_W-1:0] op;
        logic [4:0]          rd;
        logic                rd_we;
        logic                illegal;
    } entry_t;

    // is_reg distinguishes OP from OP-IMM: only the register form can encode SUB.
    function automatic logic [ALU_OP_W-1:0] funct3_op(input logic [2:0] funct3,
                                                      input logic [6:0] funct7,
                                                      input logic       is_reg);
        logic [ALU_OP_W-1:0] op;
        case (funct3)
            3'b000:  op = (is_reg && funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = funct7[5] ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/alu_op_decode.sv
// rtl/alu_op_decode.sv - combinational RV32I OP/OP-IMM/LUI decode into ALU operands and op code
// Ports:
//   instr, rs1_data, rs2_data : raw instruction and its register-file reads
//   alu_in_1, alu_in_2, alu_op: ALU operands and operation
//   rd, rd_we                 : write-back destination and enable
//   illegal                   : opcode is not OP, OP-IMM or LUI
module alu_op_decode
    import alu_pkg::*;
(
    input  logic [ALU_XLEN-1:0] instr,
    input  logic [ALU_XLEN-1:0] rs1_data,
    input  logic [ALU_XLEN-1:0] rs2_data,
    output logic [ALU_XLEN-1:0] alu_in_1,
    output logic [ALU_XLEN-1:0] alu_in_2,
    output logic [ALU_OP_W-1:0] alu_op,
    output logic [4:0]          rd,
    output logic                rd_we,
    output logic                illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       is_shift;

    assign opcode   = instr[6:0];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);

    always_comb begin
        alu_in_1 = '0;
        alu_in_2 = '0;
        alu_op   = ALU_ADD;
        illegal  = 1'b0;
        case (opcode)
            OPC_OP: begin
                alu_in_1 = rs1_data;
                alu_in_2 = rs2_data;
                alu_op   = funct3_op(funct3, funct7, 1'b1);
            end
            OPC_OP_IMM: begin
                alu_in_1 = rs1_data;
                // Shift-immediates carry only a 5-bit shamt; the upper bits are the SRAI selector.
                alu_in_2 = is_shift ? {27'b0, instr[24:20]}
                                    : {{20{instr[31]}}, instr[31:20]};
                alu_op   = funct3_op(funct3, funct7, 1'b0);
            end
            OPC_LUI: begin
                alu_in_2 = {instr[31:12], 12'b0};
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign rd    = instr[11:7];
    assign rd_we = !illegal && (instr[11:7] != 5'd0);

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - ALU issue stage: decode plus 2-entry skid buffer on a valid/ready pipe
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   flush                    : synchronous drop of all buffered entries
//   in_valid, in_ready       : upstream handshake
//   instr, rs1_data, rs2_data: instruction and operands
//   out_valid, out_ready     : downstream handshake
//   alu_in_1, alu_in_2       : ALU operands
//   alu_op                   : ALU operation code
//   rd, rd_we, illegal       : write-back metadata
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int XLEN = ALU_XLEN,
    parameter int OP_W = ALU_OP_W
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_in_1,
    output logic [XLEN-1:0] alu_in_2,
    output logic [OP_W-1:0] alu_op,
    output logic [4:0]      rd,
    output logic            rd_we,
    output logic            illegal
);

    state_t state;
    state_t state_nxt;
    entry_t dec;
    entry_t out_q;
    entry_t skid_q;
    logic   accept;
    logic   pop;
    logic   load_out_dec;
    logic   load_out_skid;
    logic   load_skid;

    alu_op_decode u_decode (
        .instr    (instr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .alu_in_1 (dec.in_1),
        .alu_in_2 (dec.in_2),
        .alu_op   (dec.op),
        .rd       (dec.rd),
        .rd_we    (dec.rd_we),
        .illegal  (dec.illegal)
    );

    // Both handshake outputs come from the state register alone, so out_ready
    // never reaches in_ready combinationally.
    assign in_ready  = (state != ST_SKID);
    assign out_valid = (state != ST_EMPTY);
    assign accept    = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        state_nxt     = state;
        load_out_dec  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: begin
                    if (accept) begin
                        state_nxt    = ST_FULL;
                        load_out_dec = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (accept && pop) begin
                        load_out_dec = 1'b1;
                    end else if (accept) begin
                        state_nxt = ST_SKID;
                        load_skid = 1'b1;
                    end else if (pop) begin
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_SKID: begin
                    if (pop) begin
                        state_nxt     = ST_FULL;
                        load_out_skid = 1'b1;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_EMPTY;
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            state <= state_nxt;
            if (load_out_dec) begin
                out_q <= dec;
            end else if (load_out_skid) begin
                out_q <= skid_q;
            end
            if (load_skid) begin
                skid_q <= dec;
            end
        end
    end

    assign alu_in_1 = out_q.in_1;
    assign alu_in_2 = out_q.in_2;
    assign alu_op   = out_q.op;
    assign rd       = out_q.rd;
    assign rd_we    = out_q.rd_we;
    assign illegal  = out_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// tb/tb_alu_issue_stage.sv - self-checking bench for alu_issue_stage
module tb_alu_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_in_1;
    logic [31:0] alu_in_2;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        illegal;

    alu_issue_stage dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .instr     (instr),
        .rs1_data  (rs1_data),
        .rs2_data  (rs2_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .alu_in_1  (alu_in_1),
        .alu_in_2  (alu_in_2),
        .alu_op    (alu_op),
        .rd        (rd),
        .rd_we     (rd_we),
        .illegal   (illegal)
    );

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        ill;
    } exp_t;

    int          total;
    int          bad;
    exp_t        q[$];
    logic [4:0]  popped[$];
    logic        acc;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] base_op(input logic [2:0] f3);
        case (f3)
            3'd0: return 4'd0;
            3'd1: return 4'd5;
            3'd2: return 4'd8;
            3'd3: return 4'd9;
            3'd4: return 4'd2;
            3'd5: return 4'd6;
            3'd6: return 4'd3;
            default: return 4'd4;
        endcase
    endfunction

    function automatic exp_t model(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        logic [2:0] f3;
        f3    = i[14:12];
        e.a   = 32'd0;
        e.b   = 32'd0;
        e.op  = 4'd0;
        e.ill = 1'b0;
        e.rd  = i[11:7];
        if (i[6:0] == 7'h33) begin
            e.a  = r1;
            e.b  = r2;
            e.op = base_op(f3);
            if (f3 == 3'd0 && i[31:25] == 7'h20) e.op = 4'd1;
            if (f3 == 3'd5 && i[30]) e.op = 4'd7;
        end else if (i[6:0] == 7'h13) begin
            e.a  = r1;
            e.b  = {{20{i[31]}}, i[31:20]};
            e.op = base_op(f3);
            if (f3 == 3'd1 || f3 == 3'd5) e.b = {27'd0, i[24:20]};
            if (f3 == 3'd5 && i[30]) e.op = 4'd7;
        end else if (i[6:0] == 7'h37) begin
            e.b = {i[31:12], 12'd0};
        end else begin
            e.ill = 1'b1;
        end
        e.we = !e.ill && (e.rd != 5'd0);
        return e;
    endfunction

    // Reference occupancy model: a queue of at most two decoded entries.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            acc = 1'b0;
        end else if (flush) begin
            q.delete();
            acc = 1'b0;
        end else begin
            logic do_pop;
            do_pop = out_ready && (q.size() != 0);
            acc    = in_valid && (q.size() < 2);
            if (do_pop) q.delete(0);
            if (acc) q.push_back(model(instr, rs1_data, rs2_data));
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
            chk("in_ready", 32'(in_ready), 32'(q.size() < 2));
            if (q.size() != 0 && out_valid) begin
                chk("alu_in_1", alu_in_1, q[0].a);
                chk("alu_in_2", alu_in_2, q[0].b);
                chk("alu_op", 32'(alu_op), 32'(q[0].op));
                chk("rd", 32'(rd), 32'(q[0].rd));
                chk("rd_we", 32'(rd_we), 32'(q[0].we));
                chk("illegal", 32'(illegal), 32'(q[0].ill));
            end
            if (out_valid && out_ready) popped.push_back(rd);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [31:0] i, input logic [31:0] r1, input logic [31:0] r2);
        bit done;
        done     = 1'b0;
        instr    = i;
        rs1_data = r1;
        rs2_data = r2;
        in_valid = 1'b1;
        for (int n = 0; n < 20 && !done; n++) begin
            cyc();
            done = acc;
        end
        if (!done) begin
            total++;
            bad++;
            $display("FAIL send_timeout: instr 0x%08h not accepted", i);
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) cyc();
    endtask

    function automatic logic [31:0] rtype(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] d);
        return {f7, 5'd2, 5'd1, f3, d, 7'h33};
    endfunction

    function automatic logic [31:0] itype(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] d);
        return {imm, 5'd1, f3, d, 7'h13};
    endfunction

    initial begin
        total     = 0;
        bad       = 0;
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        instr     = 32'd0;
        rs1_data  = 32'd0;
        rs2_data  = 32'd0;

        #3;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_alu_in_1", alu_in_1, 32'd0);
        chk("rst_alu_in_2", alu_in_2, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        chk("rst_rd", 32'(rd), 32'd0);
        chk("rst_rd_we", 32'(rd_we), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        #9 rst_n = 1'b1;
        cyc();

        out_ready = 1'b1;
        send(32'h402081B3, 32'd5, 32'd7);
        chk("sub_op", 32'(alu_op), 32'd1);
        chk("sub_in_1", alu_in_1, 32'd5);
        chk("sub_in_2", alu_in_2, 32'd7);
        chk("sub_rd", 32'(rd), 32'd3);
        chk("sub_rd_we", 32'(rd_we), 32'd1);
        send(32'hFFF00093, 32'd9, 32'd0);
        chk("addi_in_2", alu_in_2, 32'hFFFFFFFF);
        chk("addi_op", 32'(alu_op), 32'd0);
        send(32'h40415113, 32'h80000000, 32'd3);
        chk("srai_op", 32'(alu_op), 32'd7);
        chk("srai_in_2", alu_in_2, 32'd4);
        send(32'h123452B7, 32'hDEAD, 32'hBEEF);
        chk("lui_in_1", alu_in_1, 32'd0);
        chk("lui_in_2", alu_in_2, 32'h12345000);
        send(32'h00000083, 32'd1, 32'd2);
        chk("ill_illegal", 32'(illegal), 32'd1);
        chk("ill_rd_we", 32'(rd_we), 32'd0);
        send(32'h00208033, 32'd1, 32'd2);
        chk("x0_rd_we", 32'(rd_we), 32'd0);
        chk("x0_illegal", 32'(illegal), 32'd0);

        // Back-to-back sweep of every funct3 in both formats.
        for (int f = 0; f < 8; f++) begin
            send(rtype(7'h00, 3'(f), 5'(f + 1)), 32'h1234_5678 + 32'(f), 32'hF0F0_0F0F);
            send(rtype(7'h20, 3'(f), 5'(f + 9)), 32'h8000_0001, 32'(f));
            send(itype(12'h8A5 ^ 12'(f << 4), 3'(f), 5'(f + 17)), 32'hCAFE_0000, 32'd0);
        end
        send(rtype(7'h01, 3'd0, 5'd31), 32'd10, 32'd20);
        send(32'hFFFFF0B7, 32'd1, 32'd1);
        idle(2);

        // Backpressure: A,B fill output and skid, C must stall.
        out_ready = 1'b0;
        popped.delete();
        send(itype(12'd1, 3'd0, 5'd10), 32'd100, 32'd0);
        send(itype(12'd2, 3'd0, 5'd11), 32'd200, 32'd0);
        instr    = itype(12'd3, 3'd0, 5'd12);
        in_valid = 1'b1;
        cyc();
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_rd", 32'(rd), 32'd10);
        out_ready = 1'b1;
        send(itype(12'd3, 3'd0, 5'd12), 32'd300, 32'd0);
        idle(4);
        chk("bp_count", 32'(popped.size()), 32'd3);
        if (popped.size() == 3) begin
            chk("bp_order0", 32'(popped[0]), 32'd10);
            chk("bp_order1", 32'(popped[1]), 32'd11);
            chk("bp_order2", 32'(popped[2]), 32'd12);
        end

        // Flush from SKID with an incoming instruction.
        out_ready = 1'b0;
        send(itype(12'd4, 3'd0, 5'd13), 32'd1, 32'd0);
        send(itype(12'd5, 3'd0, 5'd14), 32'd1, 32'd0);
        instr    = itype(12'd6, 3'd0, 5'd15);
        in_valid = 1'b1;
        flush    = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush_out_valid", 32'(out_valid), 32'd0);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        // Flush from FULL while an accept is presented.
        send(itype(12'd7, 3'd0, 5'd16), 32'd1, 32'd0);
        instr    = itype(12'd8, 3'd0, 5'd17);
        in_valid = 1'b1;
        flush    = 1'b1;
        cyc();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("flush2_out_valid", 32'(out_valid), 32'd0);
        popped.delete();
        out_ready = 1'b1;
        idle(3);
        chk("flush_nothing_out", 32'(popped.size()), 32'd0);

        // Asynchronous reset while holding a valid output.
        out_ready = 1'b0;
        send(32'h402081B3, 32'd5, 32'd7);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_in_ready", 32'(in_ready), 32'd1);
        chk("arst_alu_in_1", alu_in_1, 32'd0);
        chk("arst_alu_op", 32'(alu_op), 32'd0);
        chk("arst_rd_we", 32'(rd_we), 32'd0);
        #4 rst_n = 1'b1;
        out_ready = 1'b1;
        idle(2);
        send(32'h00209233, 32'd3, 32'd4);
        idle(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
